// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: one column low per SCAN_DIV cycles, whole-scan debounce,
// one-cycle key_valid strobe plus key_down level; outputs update the cycle after each scan ends.
module keypad_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk100MHz,
  input  logic       reset_n,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  logic [3:0]    row_s1, row_s2;
  logic [CW-1:0] col_cnt;
  logic [1:0]    col_idx;
  logic [3:0]    samp [3];
  state_t        state;
  logic [DW-1:0] deb;
  logic [3:0]    cand;

  logic          scan_done;
  logic [3:0]    scan_rows [4];
  logic          any_hit, multi_hit;
  logic [3:0]    hit_code;
  logic          res_none, res_key;
  logic [DW-1:0] deb_inc;
  logic          deb_done;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
    endcase
  endfunction

  assign COL       = ~(4'b0001 << col_idx);
  assign scan_done = (col_cnt == CNT_MAX) && (col_idx == 2'd3);

  // Column 3 is classified straight from the synchronizer on the edge it would be stored.
  always_comb begin
    scan_rows[0] = samp[0];
    scan_rows[1] = samp[1];
    scan_rows[2] = samp[2];
    scan_rows[3] = row_s2;
    any_hit   = 1'b0;
    multi_hit = 1'b0;
    hit_code  = 4'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!scan_rows[c][r]) begin
          if (any_hit) multi_hit = 1'b1;
          any_hit  = 1'b1;
          hit_code = key_map(2'(r), 2'(c));
        end
      end
    end
    res_none = !any_hit;
    res_key  = any_hit && !multi_hit;
  end

  assign deb_inc  = (deb >= DEB_MAX) ? DEB_MAX : deb + DW'(1);
  assign deb_done = (deb_inc == DEB_MAX);

  always_ff @(posedge clk100MHz) begin
    if (!reset_n) begin
      row_s1    <= 4'hF;
      row_s2    <= 4'hF;
      col_cnt   <= '0;
      col_idx   <= 2'd0;
      samp[0]   <= 4'hF;
      samp[1]   <= 4'hF;
      samp[2]   <= 4'hF;
      state     <= IDLE;
      deb       <= '0;
      cand      <= 4'h0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      row_s1    <= ROW;
      row_s2    <= row_s1;
      key_valid <= 1'b0;

      if (col_cnt == CNT_MAX) begin
        col_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        case (col_idx)
          2'd0:    samp[0] <= row_s2;
          2'd1:    samp[1] <= row_s2;
          2'd2:    samp[2] <= row_s2;
          default: ;
        endcase
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end

      if (scan_done) begin
        case (state)
          IDLE: begin
            if (res_key) begin
              cand <= hit_code;
              deb  <= DW'(1);
              if (DEBOUNCE_SCANS == 1) begin
                key_code  <= hit_code;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                state     <= HELD;
              end else begin
                state <= PRESS;
              end
            end
          end
          PRESS: begin
            if (res_key && hit_code == cand) begin
              deb <= deb_inc;
              if (deb_done) begin
                key_code  <= cand;
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                state     <= HELD;
              end
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            // Rollover (MULTI) keeps the current key held.
            if (res_none || (res_key && hit_code != key_code)) begin
              deb <= DW'(1);
              if (DEBOUNCE_SCANS == 1) begin
                key_down <= 1'b0;
                state    <= IDLE;
              end else begin
                state <= RELEASE;
              end
            end
          end
          default: begin
            if (res_none || (res_key && hit_code != key_code)) begin
              deb <= deb_inc;
              if (deb_done) begin
                key_down <= 1'b0;
                state    <= IDLE;
              end
            end else begin
              state <= HELD;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_DIV=8, DEBOUNCE_SCANS=3, 32-cycle scans) with a keypad
// model and a scoreboard queue of expected key codes checked on every key_valid strobe.
module tb_keypad_scan;

  logic        clk100MHz = 1'b0;
  logic        reset_n   = 1'b0;
  logic [3:0]  ROW;
  logic [3:0]  COL;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_down;

  logic [15:0] pressed = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          vld_cnt = 0;
  int          last_vld_cyc = -1;
  logic [3:0]  exp_q [$];

  keypad_scan #(.SCAN_DIV(8), .DEBOUNCE_SCANS(3)) dut (
    .clk100MHz (clk100MHz),
    .reset_n   (reset_n),
    .ROW       (ROW),
    .COL       (COL),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clk100MHz = ~clk100MHz;

  // Keypad: a pressed key shorts its row to the column currently driven low.
  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !COL[c]) ROW[r] = 1'b0;
  end

  always @(posedge clk100MHz) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk100MHz);
  endtask

  always @(negedge clk100MHz) begin : mon
    logic [3:0] e;
    if (reset_n && key_valid) begin
      vld_cnt++;
      last_vld_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("spurious_vld", {31'd0, key_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("vld_code", {28'd0, key_code}, {28'd0, e});
      end
    end
  end

  initial begin : stim
    logic [3:0] ec;
    reset_n = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk100MHz);
    chk("rst_col", COL, 4'b1110);
    chk("rst_code", key_code, 0);
    chk("rst_vld", key_valid, 0);
    chk("rst_down", key_down, 0);

    // Release reset: this negedge is cycle 0. Press '6' (row 1, col 2) before scan 1.
    reset_n = 1'b1;
    pressed[6] = 1'b1;
    exp_q.push_back(4'h6);
    for (int n = 0; n < 40; n++) begin
      ec = ~(4'b0001 << ((n / 8) % 4));
      chk("col_scan", COL, ec);
      chk("scan_vld", key_valid, 0);
      chk("scan_down", key_down, 0);
      @(negedge clk100MHz);
    end

    wait_cyc(95);
    chk("pre_vld", key_valid, 0);
    chk("pre_down", key_down, 0);
    wait_cyc(96);
    chk("acc6_vld", key_valid, 1);
    chk("acc6_code", key_code, 4'h6);
    chk("acc6_down", key_down, 1);
    wait_cyc(97);
    chk("acc6_cycle", last_vld_cyc, 96);
    chk("acc6_strobe_len", key_valid, 0);

    wait_cyc(416);
    chk("hold6_cnt", vld_cnt, 1);
    chk("hold6_down", key_down, 1);
    chk("hold6_code", key_code, 4'h6);
    pressed = '0;
    wait_cyc(480);
    chk("rel6_mid", key_down, 1);
    wait_cyc(511);
    chk("rel6_pre", key_down, 1);
    wait_cyc(512);
    chk("rel6_fall", key_down, 0);

    // Bounce on '0': 1 scan on, 1 off, 2 on, then off.
    pressed[12] = 1'b1;
    wait_cyc(544); pressed = '0;
    wait_cyc(576); pressed[12] = 1'b1;
    wait_cyc(640); pressed = '0;
    wait_cyc(672);
    chk("bounce_down", key_down, 0);
    wait_cyc(704);
    chk("bounce_down2", key_down, 0);
    chk("bounce_cnt", vld_cnt, 1);

    // '1' and '5' together from IDLE.
    pressed[0] = 1'b1;
    pressed[5] = 1'b1;
    wait_cyc(864);
    chk("multi_cnt", vld_cnt, 1);
    chk("multi_down", key_down, 0);

    // 'A' held, dropped for one scan, re-pressed.
    pressed = '0;
    pressed[3] = 1'b1;
    exp_q.push_back(4'hA);
    wait_cyc(960);
    chk("accA_vld", key_valid, 1);
    chk("accA_code", key_code, 4'hA);
    pressed = '0;
    wait_cyc(992);
    chk("accA_cnt", vld_cnt, 2);
    chk("dropA_down", key_down, 1);
    pressed[3] = 1'b1;
    wait_cyc(1024);
    chk("repA_down", key_down, 1);
    wait_cyc(1056);
    chk("repA_down2", key_down, 1);
    chk("repA_cnt", vld_cnt, 2);
    chk("repA_code", key_code, 4'hA);
    pressed = '0;
    wait_cyc(1151);
    chk("relA_pre", key_down, 1);
    wait_cyc(1152);
    chk("relA_fall", key_down, 0);

    // 'D' held, then '9' added.
    pressed[15] = 1'b1;
    exp_q.push_back(4'hD);
    wait_cyc(1248);
    chk("accD_vld", key_valid, 1);
    chk("accD_code", key_code, 4'hD);
    wait_cyc(1280);
    pressed[10] = 1'b1;
    wait_cyc(1408);
    chk("rollD_down", key_down, 1);
    chk("rollD_code", key_code, 4'hD);
    chk("rollD_cnt", vld_cnt, 3);
    pressed = '0;
    wait_cyc(1504);
    chk("relD_down", key_down, 0);

    // '8' for two qualifying scans, then reset with the key still held.
    pressed[9] = 1'b1;
    wait_cyc(1568);
    chk("pre_rst_down", key_down, 0);
    reset_n = 1'b0;
    repeat (2) @(negedge clk100MHz);
    chk("mid_rst_code", key_code, 0);
    chk("mid_rst_down", key_down, 0);
    chk("mid_rst_col", COL, 4'b1110);
    reset_n = 1'b1;
    exp_q.push_back(4'h8);
    wait_cyc(64);
    chk("r8_early_cnt", vld_cnt, 3);
    wait_cyc(95);
    chk("r8_pre_vld", key_valid, 0);
    wait_cyc(96);
    chk("r8_vld", key_valid, 1);
    chk("r8_code", key_code, 4'h8);
    wait_cyc(128);
    chk("r8_cnt", vld_cnt, 4);
    chk("r8_down", key_down, 1);
    chk("queue_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
